// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: mdop encodings used by
// both the decoder that drives mdop and the unit itself, plus counter sizing.
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int MD_CNT_W = 4;

  // True for the operations that occupy the unit for several cycles.
  function automatic logic is_md_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage command and HI/LO result bundle between the pipeline and md_unit.
interface md_unit_if;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, mdop, A, B, input busy, hi, lo);
  modport slave  (input start, mdop, A, B, output busy, hi, lo);
endinterface

// File: rtl/md_calc.sv
// Combinational 64-bit result generator: {op, A, B, hi, lo} -> {phi, plo},
// including signed-divide sign fixup and the divide-by-zero hold.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] phi_o,
  output logic [31:0] plo_o
);

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic        b_zero;
  logic [31:0] b_div;
  logic [31:0] u_q;
  logic [31:0] u_r;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] mag_q;
  logic [31:0] mag_r;

  assign sprod = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign uprod = {32'b0, a_i} * {32'b0, b_i};

  // A zero divisor is replaced by 1 so the dividers never see it; the result
  // is discarded in that case anyway.
  assign b_zero = (b_i == '0);
  assign b_div  = b_zero ? 32'd1 : b_i;

  assign u_q = a_i / b_div;
  assign u_r = a_i % b_div;

  // Signed divide on magnitudes; 0x80000000 has magnitude 0x80000000 unsigned,
  // which makes the -2^31 / -1 case fall out as 0x80000000 with remainder 0.
  assign a_mag = a_i[31]   ? -a_i   : a_i;
  assign b_mag = b_div[31] ? -b_div : b_div;
  assign mag_q = a_mag / b_mag;
  assign mag_r = a_mag % b_mag;

  // NOTE: every output gets a default at the top so no path infers a latch.
  always_comb begin
    phi_o = hi_i;
    plo_o = lo_i;
    case (op_i)
      MD_MULT:  {phi_o, plo_o} = sprod;
      MD_MULTU: {phi_o, plo_o} = uprod;
      MD_DIV: begin
        if (!b_zero) begin
          plo_o = (a_i[31] ^ b_i[31]) ? -mag_q : mag_q;
          phi_o = a_i[31] ? -mag_r : mag_r;
        end
      end
      MD_DIVU: begin
        if (!b_zero) begin
          plo_o = u_q;
          phi_o = u_r;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, sequences a fixed-latency busy
// window per operation and commits the precomputed result at its end.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  md_unit_if.slave     bus
);

  logic [MD_CNT_W-1:0] count_q;
  logic [31:0]         phi_q;
  logic [31:0]         plo_q;
  logic [31:0]         hi_q;
  logic [31:0]         lo_q;
  logic [31:0]         phi_d;
  logic [31:0]         plo_d;
  logic                busy_q;

  md_calc u_calc (
    .op_i  (bus.mdop),
    .a_i   (bus.A),
    .b_i   (bus.B),
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .phi_o (phi_d),
    .plo_o (plo_d)
  );

  assign busy_q = (count_q != '0);

  // Raised in the start cycle itself so an md instruction in D stalls at once.
  assign bus.busy = (bus.start & reset_n & is_md_op(bus.mdop)) | busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (busy_q) begin
      // Commands arriving while occupied, including the commit cycle, are dropped.
      count_q <= count_q - MD_CNT_W'(1);
      if (count_q == MD_CNT_W'(1)) begin
        hi_q <= phi_q;
        lo_q <= plo_q;
      end
    end else if (bus.start) begin
      case (bus.mdop)
        MD_MULT, MD_MULTU: begin
          count_q <= MD_CNT_W'(MULT_CYCLES);
          phi_q   <= phi_d;
          plo_q   <= plo_d;
        end
        MD_DIV, MD_DIVU: begin
          count_q <= MD_CNT_W'(DIV_CYCLES);
          phi_q   <= phi_d;
          plo_q   <= plo_d;
        end
        MD_MTHI: hi_q <= bus.A;
        MD_MTLO: lo_q <= bus.A;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed table, multi-cycle corner
// sequences and randomized traffic against a cycle-scheduled reference model.
module tb_md_unit;
  import md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: architectural HI/LO plus a scheduled commit.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pend;
  int          free_cyc;

  logic        s_busy;
  logic [31:0] s_hi, s_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
    m_pend = 1'b0;
    free_cyc = 0;
  endtask

  // Arithmetic definitions of the four operations; zero divisor keeps HI/LO.
  task automatic model_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] ph, output logic [31:0] pl);
    longint sa, sb, q, r;
    logic [63:0] up;
    ph = m_hi;
    pl = m_lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == MD_MULT) begin
      q = sa * sb;
      ph = 32'(q >>> 32);
      pl = 32'(q);
    end else if (op == MD_MULTU) begin
      up = 64'(a) * 64'(b);
      ph = up[63:32];
      pl = up[31:0];
    end else if (op == MD_DIV && b != 0) begin
      q = sa / sb;
      r = sa % sb;
      pl = 32'(q);
      ph = 32'(r);
    end else if (op == MD_DIVU && b != 0) begin
      pl = a / b;
      ph = a % b;
    end
  endtask

  task automatic step(input logic st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic exp_busy;
    bus.start = st;
    bus.mdop  = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    if (m_pend && cyc == free_cyc) begin
      m_hi = m_phi;
      m_lo = m_plo;
      m_pend = 1'b0;
    end
    exp_busy = (cyc < free_cyc) || (st && (op >= MD_MULT) && (op <= MD_DIVU));
    s_busy = bus.busy;
    s_hi   = bus.hi;
    s_lo   = bus.lo;
    check("busy", {31'b0, s_busy}, {31'b0, exp_busy});
    check("hi", s_hi, m_hi);
    check("lo", s_lo, m_lo);
    if (st && cyc >= free_cyc) begin
      if (op == MD_MULT || op == MD_MULTU) begin
        model_calc(op, a, b, m_phi, m_plo);
        free_cyc = cyc + MC + 1;
        m_pend = 1'b1;
      end else if (op == MD_DIV || op == MD_DIVU) begin
        model_calc(op, a, b, m_phi, m_plo);
        free_cyc = cyc + DC + 1;
        m_pend = 1'b1;
      end else if (op == MD_MTHI) begin
        m_hi = a;
      end else if (op == MD_MTLO) begin
        m_lo = a;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, MD_NONE, '0, '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nbusy;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    vecs[0] = '{MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[5] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[6] = '{MD_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};

    // Reset: busy must stay low even with an md command presented.
    reset_n   = 1'b0;
    bus.start = 1'b1;
    bus.mdop  = MD_MULT;
    bus.A     = 32'd3;
    bus.B     = 32'd4;
    model_reset();
    #1;
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;

    // First mult after reset: exact busy window and commit cycle.
    step(1'b1, MD_MULT, 32'hFFFFFFFD, 32'd5);
    check("mult_busy_t0", {31'b0, s_busy}, 32'd1);
    for (int i = 1; i <= MC; i++) begin
      step(1'b0, MD_NONE, '0, '0);
      check("mult_busy_win", {31'b0, s_busy}, 32'd1);
      check("mult_hi_hold", s_hi, 32'd0);
      check("mult_lo_hold", s_lo, 32'd0);
    end
    step(1'b0, MD_NONE, '0, '0);
    check("mult_busy_done", {31'b0, s_busy}, 32'd0);
    check("mult_hi", s_hi, 32'hFFFFFFFF);
    check("mult_lo", s_lo, 32'hFFFFFFF1);

    // Divide by zero keeps HI/LO but still runs the full busy window.
    step(1'b1, MD_MTHI, 32'h11, '0);
    step(1'b1, MD_MTLO, 32'h22, '0);
    step(1'b1, MD_DIVU, 32'd7, 32'd0);
    nbusy = s_busy ? 1 : 0;
    for (int i = 0; i < DC + 1; i++) begin
      step(1'b0, MD_NONE, '0, '0);
      if (s_busy) nbusy++;
    end
    check("divz_busy_cycles", 32'(nbusy), 32'(DC + 1));
    check("divz_hi", s_hi, 32'h11);
    check("divz_lo", s_lo, 32'h22);

    // mtlo while idle: immediate write, no busy.
    step(1'b1, MD_MTLO, 32'h1234, '0);
    check("mtlo_busy", {31'b0, s_busy}, 32'd0);
    step(1'b0, MD_NONE, '0, '0);
    check("mtlo_lo", s_lo, 32'h1234);
    check("mtlo_busy_after", {31'b0, s_busy}, 32'd0);

    // Commands during an active mult are ignored.
    step(1'b1, MD_MULT, 32'd5, 32'd6);
    step(1'b1, MD_MTHI, 32'hDEAD, '0);
    step(1'b1, MD_MULT, 32'd3, 32'd3);
    idle(MC - 2);
    step(1'b0, MD_NONE, '0, '0);
    check("ignore_hi", s_hi, 32'd0);
    check("ignore_lo", s_lo, 32'd30);

    // Directed vector table.
    foreach (vecs[k]) begin
      step(1'b1, vecs[k].op, vecs[k].a, vecs[k].b);
      idle(((vecs[k].op == MD_DIV) || (vecs[k].op == MD_DIVU)) ? DC : MC);
      step(1'b0, MD_NONE, '0, '0);
      check($sformatf("vec%0d_hi", k), s_hi, vecs[k].hi);
      check($sformatf("vec%0d_lo", k), s_lo, vecs[k].lo);
    end

    // Reset pulsed in cycle 3 of a divide.
    step(1'b1, MD_DIV, 32'd100, 32'd3);
    idle(2);
    bus.start = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check("midrst_hi", bus.hi, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    model_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    idle(DC + 2);
    check("midrst_no_commit", s_lo, 32'd0);
    step(1'b1, MD_MULTU, 32'd6, 32'd7);
    idle(MC);
    step(1'b0, MD_NONE, '0, '0);
    check("midrst_after_hi", s_hi, 32'd0);
    check("midrst_after_lo", s_lo, 32'd42);

    // Randomized traffic, including starts while busy and zero divisors.
    for (int i = 0; i < 400; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
      step(1'($urandom_range(0, 1)), rop, ra, rb);
    end
    idle(DC + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage pipeline. It executes mult/multu/div/divu and mthi/mtlo, and owns the HI/LO registers.
- Produces `busy`, which the hazard unit combines with the D-stage md tag to stall mfhi/mflo/md instructions.
- HI/LO outputs are read by the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles after start for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles after start for div/divu (1..15)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle qualifier: E-stage md instruction valid this cycle (low when E is flushed/bubbled)
- mdop  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  input  32  rs operand (post-forwarding)
- B  input  32  rt operand (post-forwarding)
- busy  output  1  unit occupied; to hazard unit
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (async, reset_n low): hi=0, lo=0, count=0, pending result=0, busy=0. busy is held 0 while reset_n is low, regardless of start.
- Accept condition: start=1 and busy_q=0 (count==0). If start=1 while busy_q=1, the command is ignored; the hazard unit makes this unreachable, and the bench checks it is harmless.
- Accepted mult/multu/div/divu at edge t0:
  - Compute the result into pending {phi,plo}.
  - Load count with MULT_CYCLES or DIV_CYCLES.
- busy = (start & reset_n & mdop in {1,2,3,4}) | busy_q, where busy_q = (count != 0).
  - busy is high combinationally in the start cycle t0, so an md instruction sitting in D is stalled that same cycle.
  - busy is then high in cycles t0+1 .. t0+N.
- count decrements by 1 each cycle while nonzero. On the edge where count==1, hi<=phi and lo<=plo, and count reaches 0.
- Results are visible and busy=0 in cycle t0+N+1. hi/lo keep their old values throughout cycles t0..t0+N.
- mult: {hi,lo} = signed 64-bit A*B.
- multu: {hi,lo} = unsigned 64-bit A*B.
- div: lo = A/B truncated toward zero; hi = remainder with the sign of A.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned lo = A/B, hi = A%B.
- Divide by zero (B==0, div or divu): the full DIV_CYCLES busy sequence still runs, but hi/lo are left unchanged at commit (pending = current hi/lo).
- mthi/mtlo accepted at edge t0: hi<=A or lo<=A at that edge, with no busy cycles and busy not asserted. Ignored if busy_q=1.
- mdop 0 or 7 with start: no effect.
- Reset mid-operation: count is cleared, the pending result is discarded, and hi/lo return to 0.
- No interaction between start and commit in the same cycle: start is ignored while count!=0, including the commit cycle.

Decomposition:
- Shared package (md_pkg) holds:
  - MD_NONE/MD_MULT/MD_MULTU/MD_DIV/MD_DIVU/MD_MTHI/MD_MTLO 3-bit constants, also used by the controller that drives mdop.
  - The count width constant (4).
- One sub-module, md_calc: combinational 64-bit result generator for {op,A,B,hi,lo} -> {phi,plo}. It contains the sign handling and the divide-by-zero hold.
- Sequencing (counter, busy, commit) stays in md_unit.

Test Plan:
- Reset release, then mult A=0xFFFFFFFD B=5 with start in cycle 0:
  - busy=1 in cycles 0..5, busy=0 in cycle 6.
  - hi/lo stay 0 through cycle 5; in cycle 6, hi=0xFFFFFFFF and lo=0xFFFFFFF1.
- multu A=B=0xFFFFFFFF: after 5 busy cycles, hi=0xFFFFFFFE and lo=0x00000001.
- div A=0xFFFFFFF9(-7) B=2:
  - busy=1 in cycles 0..10.
  - Cycle 11: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide cases:
  - divu A=7 B=0 after hi=0x11, lo=0x22: busy runs 10 cycles, then hi=0x11 and lo=0x22 unchanged.
  - div 0x80000000 by -1 gives lo=0x80000000, hi=0.
- Move and ignore cases:
  - mtlo A=0x1234 while idle: lo=0x1234 the next cycle, busy never rises.
  - mthi, and a second mult, issued during an active mult: both ignored, and the final hi/lo come from the first mult only.
- Reset mid-operation:
  - reset_n pulsed low in cycle 3 of a div: busy=0 and hi=lo=0 immediately.
  - After release, no commit occurs and start is accepted normally.
